sa_ram_fifo_ctrl_80x514: RTL

SA_RAM_FIFO_CTRL_80X514 -- requirements
Module: sa_ram_fifo_ctrl_80x514

---
 rtl/sa_ram_ctrl_pkg.sv | 13 +
 rtl/sa_ram_fifo_ctrl_80x514_if.sv | 22 ++
 rtl/sa_ram_ptr_wrap.sv | 23 ++
 rtl/sa_ram_fifo_ctrl_80x514.sv | 93 +++++++++
 4 files changed

// File: rtl/sa_ram_ctrl_pkg.sv
// Shared sizing defaults and pointer helper for the RAM-backed FIFO controller.
// Wrapping increment keeps RAM addresses inside 0..DEPTH-1.
package sa_ram_ctrl_pkg;

    localparam int DEPTH_D = 80;
    localparam int WIDTH_D = 514;
    localparam int AW_D    = 7;

    function automatic int ptr_inc(input int p, input int depth);
        return (p == depth - 1) ? 0 : p + 1;
    endfunction

endpackage

// File: rtl/sa_ram_fifo_ctrl_80x514_if.sv
// Producer/consumer valid-ready bundle for the RAM FIFO controller.
// slave is the controller side, master the producer/consumer side.
interface sa_ram_fifo_ctrl_80x514_if #(
    parameter int WIDTH = 514
);
    logic             wr_valid;
    logic             wr_ready;
    logic [WIDTH-1:0] wr_data;
    logic             rd_valid;
    logic             rd_ready;
    logic [WIDTH-1:0] rd_data;

    modport master (
        output wr_valid, wr_data, rd_ready,
        input  wr_ready, rd_valid, rd_data
    );

    modport slave (
        input  wr_valid, wr_data, rd_ready,
        output wr_ready, rd_valid, rd_data
    );
endinterface

// File: rtl/sa_ram_ptr_wrap.sv
// Enabled address counter that wraps from DEPTH-1 back to 0.
// Used for both the write and read-issue pointers.
module sa_ram_ptr_wrap
    import sa_ram_ctrl_pkg::*;
#(
    parameter int DEPTH = DEPTH_D,
    parameter int AW    = AW_D
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    output logic [AW-1:0] ptr
);

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (en) begin
            ptr <= AW'(ptr_inc(int'(ptr), DEPTH));
        end
    end

endmodule

// File: rtl/sa_ram_fifo_ctrl_80x514.sv
// FIFO controller around an external RAM with latched read address
// and registered output; tracks a two-stage read pipeline.
module sa_ram_fifo_ctrl_80x514
    import sa_ram_ctrl_pkg::*;
#(
    parameter int DEPTH = DEPTH_D,
    parameter int WIDTH = WIDTH_D,
    parameter int AW    = AW_D
) (
    input  logic                     clk,
    input  logic                     rst,
    sa_ram_fifo_ctrl_80x514_if.slave bus,
    output logic [AW-1:0]            fill_level,
    output logic [AW-1:0]            ram_ra,
    output logic [AW-1:0]            ram_wa,
    output logic                     ram_re,
    output logic                     ram_ore,
    output logic                     ram_we,
    output logic [WIDTH-1:0]         ram_di,
    input  logic [WIDTH-1:0]         ram_dout
);

    localparam logic [AW-1:0] FULL = AW'(DEPTH);

    logic [AW-1:0] fill_q;
    logic [AW-1:0] pend_q;
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          s1_v;
    logic          out_v;
    logic          push;
    logic          pop;

    assign bus.wr_ready = !rst && (fill_q < FULL);
    assign push         = bus.wr_valid & bus.wr_ready;
    assign bus.rd_valid = out_v & !rst;
    assign pop          = bus.rd_valid & bus.rd_ready;
    assign bus.rd_data  = ram_dout;

    // Output register only advances when its current word leaves.
    assign ram_ore = !rst & s1_v & (!out_v | bus.rd_ready);
    // Never relatch the read address while a stalled word is pending.
    assign ram_re  = !rst & (pend_q != '0) & (!s1_v | ram_ore);

    assign ram_we     = push;
    assign ram_wa     = wptr;
    assign ram_ra     = rptr;
    assign ram_di     = bus.wr_data;
    assign fill_level = rst ? '0 : fill_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            fill_q <= '0;
            pend_q <= '0;
            s1_v   <= 1'b0;
            out_v  <= 1'b0;
        end else begin
            fill_q <= fill_q + AW'(push) - AW'(pop);
            pend_q <= pend_q + AW'(push) - AW'(ram_re);
            if (ram_re) begin
                s1_v <= 1'b1;
            end else if (ram_ore) begin
                s1_v <= 1'b0;
            end
            if (ram_ore) begin
                out_v <= 1'b1;
            end else if (pop) begin
                out_v <= 1'b0;
            end
        end
    end

    sa_ram_ptr_wrap #(
        .DEPTH(DEPTH),
        .AW   (AW)
    ) u_wptr (
        .clk(clk),
        .rst(rst),
        .en (push),
        .ptr(wptr)
    );

    sa_ram_ptr_wrap #(
        .DEPTH(DEPTH),
        .AW   (AW)
    ) u_rptr (
        .clk(clk),
        .rst(rst),
        .en (ram_re),
        .ptr(rptr)
    );

endmodule
